id_scoreboard: RTL and testbench

- Parametrised register-hazard scoreboard for the ID stage of the 5-stage MIPS pipeline.
- Replaces the single-load-use compare with per-register pending state.
- Covers fixed-latency producers (ALU, load, mul) and variable-latency producers (div, cache-miss load).
- Sits beside the regfile in ID: consumes issue info, drives stallreq into the stall controller, counts stall cycles for performance monitoring.

---
 rtl/id_scoreboard_if.sv | 37 +++
 rtl/id_scoreboard.sv | 90 +++++++++
 tb/tb_id_scoreboard.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/id_scoreboard_if.sv
// Issue/complete/hazard bundle between the ID stage and its register scoreboard.
// The master is the ID stage and the slave is the scoreboard.
interface id_scoreboard_if #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int NRD  = 2,
  parameter int CW   = 3
);
  logic              id_valid;
  logic              ext_stall;
  logic [NRD-1:0]    rd_en;
  logic [NRD*AW-1:0] rd_addr;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [CW-1:0]     wr_lat;
  logic              cmpl_valid;
  logic [AW-1:0]     cmpl_addr;
  logic              stallreq;
  logic [NREG-1:0]   busy_vec;
  logic [31:0]       stall_cnt;

  modport master (
    output id_valid, ext_stall,
    output rd_en, rd_addr,
    output wr_en, wr_addr, wr_lat,
    output cmpl_valid, cmpl_addr,
    input  stallreq, busy_vec, stall_cnt
  );

  modport slave (
    input  id_valid, ext_stall,
    input  rd_en, rd_addr,
    input  wr_en, wr_addr, wr_lat,
    input  cmpl_valid, cmpl_addr,
    output stallreq, busy_vec, stall_cnt
  );
endinterface

// File: rtl/id_scoreboard.sv
// Per-register pending-write scoreboard for the ID stage.
// Tracks fixed-latency countdowns and variable-latency pending bits.
module id_scoreboard #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int NRD  = 2,
  parameter int CW   = 3
) (
  input logic             clk,
  input logic             rst_n,
  id_scoreboard_if.slave  sb
);

  logic [NREG-1:0][CW-1:0] cnt_q;
  logic [NREG-1:0]         pend_q;
  logic [NREG-1:0]         busy;
  logic [NRD-1:0]          hit;
  logic [31:0]             stall_q;
  logic                    stall;
  logic                    acc;
  logic                    issue;

  always_comb begin
    busy = '0;
    for (int r = 1; r < NREG; r++) begin
      busy[r] = pend_q[r] | (cnt_q[r] != '0);
    end
  end

  // A same-cycle variable-latency completion is forwarded from WB.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NRD; i++) begin
      logic [AW-1:0] a;
      logic          fwd;
      a = sb.rd_addr[i*AW +: AW];
      fwd = sb.cmpl_valid
          & (sb.cmpl_addr == a)
          & pend_q[a];
      hit[i] = sb.id_valid
             & sb.rd_en[i]
             & (a != '0)
             & busy[a]
             & ~fwd;
    end
  end

  assign stall = |hit;
  assign acc   = sb.id_valid & ~stall & ~sb.ext_stall;
  assign issue = acc & sb.wr_en & (sb.wr_addr != '0);

  // Later assignments override: decrement, then completion, then issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      pend_q <= '0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (!sb.ext_stall && cnt_q[r] != '0) begin
          cnt_q[r] <= cnt_q[r] - CW'(1);
        end
        if (sb.cmpl_valid && sb.cmpl_addr == AW'(r)) begin
          pend_q[r] <= 1'b0;
        end
        if (issue && sb.wr_addr == AW'(r)) begin
          if (sb.wr_lat != '0) begin
            cnt_q[r]  <= sb.wr_lat;
            pend_q[r] <= 1'b0;
          end else begin
            cnt_q[r]  <= '0;
            pend_q[r] <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (stall && stall_q != '1) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign sb.stallreq  = stall;
  assign sb.busy_vec  = busy;
  assign sb.stall_cnt = stall_q;

endmodule

// File: tb/tb_id_scoreboard.sv
// Directed bench for id_scoreboard: load-use, freeze, variable latency,
// collision, r0/self-read and mid-run reset.
module tb_id_scoreboard;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  id_scoreboard_if #(
    .NREG(32), .AW(5), .NRD(2), .CW(3)
  ) sb ();

  id_scoreboard #(
    .NREG(32), .AW(5), .NRD(2), .CW(3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sb    (sb)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    sb.id_valid   = 1'b0;
    sb.ext_stall  = 1'b0;
    sb.rd_en      = 2'b00;
    sb.rd_addr    = '0;
    sb.wr_en      = 1'b0;
    sb.wr_addr    = '0;
    sb.wr_lat     = '0;
    sb.cmpl_valid = 1'b0;
    sb.cmpl_addr  = '0;
  endtask

  task automatic step();
    @(negedge clk);
    idle();
  endtask

  task automatic wr(input logic [4:0] a, input logic [2:0] lat);
    sb.id_valid = 1'b1;
    sb.wr_en    = 1'b1;
    sb.wr_addr  = a;
    sb.wr_lat   = lat;
  endtask

  task automatic rd(input logic [1:0] en,
                    input logic [4:0] rs,
                    input logic [4:0] rt);
    sb.id_valid = 1'b1;
    sb.rd_en    = en;
    sb.rd_addr  = {rt, rs};
  endtask

  initial begin
    idle();
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", sb.busy_vec, 32'h0);
    check("rst_stall", {31'b0, sb.stallreq}, 32'h0);
    check("rst_cnt", sb.stall_cnt, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Load-use with one independent instruction in between
    step(); wr(5'd8, 3'd2); #1;
    check("lu_issue", {31'b0, sb.stallreq}, 32'h0);
    step(); sb.id_valid = 1'b1; #1;
    check("lu_busy8", {31'b0, sb.busy_vec[8]}, 32'h1);
    step(); rd(2'b01, 5'd8, 5'd0); #1;
    check("lu_stall", {31'b0, sb.stallreq}, 32'h1);
    step(); rd(2'b01, 5'd8, 5'd0); #1;
    check("lu_clear", {31'b0, sb.stallreq}, 32'h0);
    check("lu_free8", {31'b0, sb.busy_vec[8]}, 32'h0);
    check("lu_cnt", sb.stall_cnt, 32'd1);

    // Counter frozen while ext_stall holds the pipe
    step(); wr(5'd9, 3'd3); #1;
    check("fz_issue", {31'b0, sb.stallreq}, 32'h0);
    for (int k = 0; k < 4; k++) begin
      step(); sb.ext_stall = 1'b1; #1;
      check("fz_hold9", {31'b0, sb.busy_vec[9]}, 32'h1);
    end
    for (int k = 0; k < 3; k++) begin
      step(); rd(2'b10, 5'd0, 5'd9); #1;
      check("fz_stall", {31'b0, sb.stallreq}, 32'h1);
    end
    step(); rd(2'b10, 5'd0, 5'd9); #1;
    check("fz_clear", {31'b0, sb.stallreq}, 32'h0);
    check("fz_cnt", sb.stall_cnt, 32'd4);

    // Variable latency completes on the sixth read cycle
    step(); wr(5'd10, 3'd0); #1;
    check("vl_issue", {31'b0, sb.stallreq}, 32'h0);
    for (int k = 0; k < 5; k++) begin
      step(); rd(2'b10, 5'd0, 5'd10); #1;
      check("vl_stall", {31'b0, sb.stallreq}, 32'h1);
    end
    step(); rd(2'b10, 5'd0, 5'd10);
    sb.cmpl_valid = 1'b1; sb.cmpl_addr = 5'd10; #1;
    check("vl_fwd", {31'b0, sb.stallreq}, 32'h0);
    check("vl_busy_pre", {31'b0, sb.busy_vec[10]}, 32'h1);
    step(); #1;
    check("vl_free10", {31'b0, sb.busy_vec[10]}, 32'h0);
    check("vl_cnt", sb.stall_cnt, 32'd9);

    // Issue and completion collide on r12: new producer wins
    step(); wr(5'd12, 3'd0); #1;
    step(); wr(5'd12, 3'd0);
    sb.cmpl_valid = 1'b1; sb.cmpl_addr = 5'd12; #1;
    check("co_nostall", {31'b0, sb.stallreq}, 32'h0);
    step(); rd(2'b01, 5'd12, 5'd0); #1;
    check("co_busy12", {31'b0, sb.busy_vec[12]}, 32'h1);
    check("co_stall", {31'b0, sb.stallreq}, 32'h1);
    step(); sb.cmpl_valid = 1'b1; sb.cmpl_addr = 5'd12; #1;
    check("co_pre12", {31'b0, sb.busy_vec[12]}, 32'h1);
    step(); #1;
    check("co_free12", {31'b0, sb.busy_vec[12]}, 32'h0);

    // r0 never becomes pending; self-read does not stall
    step(); wr(5'd0, 3'd0); #1;
    check("r0_issue", {31'b0, sb.stallreq}, 32'h0);
    step(); rd(2'b11, 5'd0, 5'd0);
    sb.cmpl_valid = 1'b1; sb.cmpl_addr = 5'd0; #1;
    check("r0_read", {31'b0, sb.stallreq}, 32'h0);
    check("r0_busy", sb.busy_vec, 32'h0);
    step(); rd(2'b01, 5'd4, 5'd0); wr(5'd4, 3'd2); #1;
    check("self_rd", {31'b0, sb.stallreq}, 32'h0);
    step(); #1;
    check("self_busy", sb.busy_vec, 32'h0000_0010);

    // Reset mid-run with r5 variable-pending
    step(); wr(5'd5, 3'd0); #1;
    step(); rd(2'b01, 5'd5, 5'd0); #1;
    check("mr_stall", {31'b0, sb.stallreq}, 32'h1);
    step(); rd(2'b01, 5'd5, 5'd0); #1;
    check("mr_cnt_pre", sb.stall_cnt, 32'd11);
    check("mr_busy_pre", sb.busy_vec, 32'h0000_0020);
    rst_n = 1'b0; #1;
    check("mr_busy", sb.busy_vec, 32'h0);
    check("mr_stallreq", {31'b0, sb.stallreq}, 32'h0);
    check("mr_cnt", sb.stall_cnt, 32'h0);
    step(); rst_n = 1'b1; rd(2'b01, 5'd5, 5'd0); #1;
    check("mr_after", {31'b0, sb.stallreq}, 32'h0);
    step(); #1;
    check("mr_cnt_after", sb.stall_cnt, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
